// File: rtl/johnson_pkg.sv
// -----------------------------------------------------------------------------
// johnson_pkg
// Shared definitions for Johnson-code consumers.
//   state_t           : monitor FSM states (EMPTY / LOCKED / FAULT)
//   idx_width()       : number of bits needed to hold an index 0..2N-1
//   JC3_ILLEGAL_A/B   : the two illegal 3-bit Johnson codes
// -----------------------------------------------------------------------------
package johnson_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    // Bits needed to represent the 2N positions of an N-bit Johnson ring.
    function automatic int idx_width(input int n);
        return $clog2(2 * n);
    endfunction

    localparam logic [2:0] JC3_ILLEGAL_A = 3'b010;
    localparam logic [2:0] JC3_ILLEGAL_B = 3'b101;

endpackage : johnson_pkg

// File: rtl/johnson_to_bin.sv
// -----------------------------------------------------------------------------
// johnson_to_bin
// Purely combinational Johnson-code to binary-index decoder.
// Ports:
//   code  in  N      Johnson code
//   idx   out IDX_W  decoded position 0..2N-1 (only meaningful when legal=1)
//   legal out 1      code is one of the 2N valid Johnson patterns
// -----------------------------------------------------------------------------
module johnson_to_bin
    import johnson_pkg::*;
#(
    parameter int N     = 3,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     code,
    output logic [IDX_W-1:0] idx,
    output logic             legal
);

    localparam int ONES_W = $clog2(N + 1);

    logic [ONES_W-1:0] w_ones;
    logic [N-1:0]      w_low_mask;
    logic [N-1:0]      w_high_mask;

    always_comb begin
        w_ones = '0;
        for (int i = 0; i < N; i++) begin
            w_ones = w_ones + ONES_W'(code[i]);
        end
    end

    // A legal code is fully determined by its population count: the ones
    // are packed against the LSB (filling phase) or against the MSB
    // (draining phase). Build both reference patterns and compare.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_mask
            assign w_low_mask[gi]  = (w_ones > ONES_W'(gi));
            assign w_high_mask[gi] = (w_ones >= ONES_W'(N - gi));
        end
    endgenerate

    always_comb begin
        idx   = '0;
        legal = 1'b0;
        if (code == '0) begin
            legal = 1'b1;
        end else if (code[0]) begin
            legal = (code == w_low_mask);
            idx   = IDX_W'(w_ones);
        end else begin
            legal = (code == w_high_mask);
            // Modular subtraction stays correct even when 2N == 2**IDX_W.
            idx   = IDX_W'(2 * N) - IDX_W'(w_ones);
        end
    end

endmodule : johnson_to_bin

// File: rtl/johnson_decode_monitor.sv
// -----------------------------------------------------------------------------
// johnson_decode_monitor
// Samples a Johnson counter output on a strobe, decodes it, checks that each
// new sample is a hold or a single +1/-1 step, tracks direction and net wraps.
// Ports:
//   clock       in  1      system clock
//   reset       in  1      asynchronous active-low reset
//   sample_en   in  1      code_in is sampled this cycle
//   code_in     in  N      Johnson code
//   clr_err     in  1      synchronous clear of err_sticky (set wins)
//   bin_out     out IDX_W  index of the last legal sample
//   code_valid  out 1      high while LOCKED
//   dir_up      out 1      direction of the last step (1 = up)
//   step_err    out 1      one-cycle pulse on illegal code / skipped step
//   err_sticky  out 1      latched error flag
//   wrap_pulse  out 1      one-cycle pulse on a wrap in either direction
//   wrap_count  out CNT_W  up-wraps minus down-wraps, modulo 2**CNT_W
// -----------------------------------------------------------------------------
module johnson_decode_monitor
    import johnson_pkg::*;
#(
    parameter int N     = 3,
    parameter int IDX_W = idx_width(N),
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [N-1:0]     code_in,
    input  logic             clr_err,
    output logic [IDX_W-1:0] bin_out,
    output logic             code_valid,
    output logic             dir_up,
    output logic             step_err,
    output logic             err_sticky,
    output logic             wrap_pulse,
    output logic [CNT_W-1:0] wrap_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * N - 1);

    state_t           r_state,      w_state_next;
    logic [IDX_W-1:0] r_bin,        w_bin_next;
    logic             r_dir_up,     w_dir_up_next;
    logic             r_step_err,   w_step_err_next;
    logic             r_err_sticky, w_err_sticky_next;
    logic             r_wrap_pulse, w_wrap_pulse_next;
    logic [CNT_W-1:0] r_wrap_count, w_wrap_count_next;

    logic [IDX_W-1:0] w_idx;
    logic             w_legal;
    logic [IDX_W-1:0] w_idx_up;
    logic [IDX_W-1:0] w_idx_dn;
    logic             w_err_set;

    johnson_to_bin #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_dec (
        .code  (code_in),
        .idx   (w_idx),
        .legal (w_legal)
    );

    // Neighbours of the current position on the 2N-state ring.
    assign w_idx_up = (r_bin == LAST_IDX) ? '0 : r_bin + IDX_W'(1);
    assign w_idx_dn = (r_bin == '0) ? LAST_IDX : r_bin - IDX_W'(1);

    always_comb begin
        w_state_next      = r_state;
        w_bin_next        = r_bin;
        w_dir_up_next     = r_dir_up;
        w_wrap_count_next = r_wrap_count;
        w_wrap_pulse_next = 1'b0;
        w_err_set         = 1'b0;

        if (sample_en) begin
            case (r_state)
                EMPTY: begin
                    if (w_legal) begin
                        w_state_next = LOCKED;
                        w_bin_next   = w_idx;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
                LOCKED: begin
                    if (!w_legal) begin
                        w_state_next = FAULT;
                        w_err_set    = 1'b1;
                    end else if (w_idx == r_bin) begin
                        // hold: nothing changes
                    end else if (w_idx == w_idx_up) begin
                        w_bin_next    = w_idx;
                        w_dir_up_next = 1'b1;
                        if (r_bin == LAST_IDX) begin
                            w_wrap_count_next = r_wrap_count + CNT_W'(1);
                            w_wrap_pulse_next = 1'b1;
                        end
                    end else if (w_idx == w_idx_dn) begin
                        w_bin_next    = w_idx;
                        w_dir_up_next = 1'b0;
                        if (r_bin == '0) begin
                            w_wrap_count_next = r_wrap_count - CNT_W'(1);
                            w_wrap_pulse_next = 1'b1;
                        end
                    end else begin
                        w_state_next = FAULT;
                        w_err_set    = 1'b1;
                    end
                end
                FAULT: begin
                    // Resync: accept any legal position without judging the step.
                    if (w_legal) begin
                        w_state_next = LOCKED;
                        w_bin_next   = w_idx;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
                default: begin
                    w_state_next = EMPTY;
                end
            endcase
        end

        w_step_err_next   = w_err_set;
        // A new error in the same cycle as clr_err keeps the flag set.
        w_err_sticky_next = w_err_set | (r_err_sticky & ~clr_err);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= EMPTY;
            r_bin        <= '0;
            r_dir_up     <= 1'b1;
            r_step_err   <= 1'b0;
            r_err_sticky <= 1'b0;
            r_wrap_pulse <= 1'b0;
            r_wrap_count <= '0;
        end else begin
            r_state      <= w_state_next;
            r_bin        <= w_bin_next;
            r_dir_up     <= w_dir_up_next;
            r_step_err   <= w_step_err_next;
            r_err_sticky <= w_err_sticky_next;
            r_wrap_pulse <= w_wrap_pulse_next;
            r_wrap_count <= w_wrap_count_next;
        end
    end

    assign bin_out    = r_bin;
    assign code_valid = (r_state == LOCKED);
    assign dir_up     = r_dir_up;
    assign step_err   = r_step_err;
    assign err_sticky = r_err_sticky;
    assign wrap_pulse = r_wrap_pulse;
    assign wrap_count = r_wrap_count;

endmodule : johnson_decode_monitor

// File: doc/johnson_decode_monitor.md
Name: johnson_decode_monitor

Overview:
- Downstream consumer of the up/down Johnson counter's `out` bus.
- Samples the Johnson code on a strobe and decodes it to a binary index (0..2N-1).
- Checks that every new sample is a legal single step: hold, +1 or -1 modulo 2N.
- Reports count direction, wraps the sequence with a signed wrap counter, and flags illegal codes or skipped states.

Parameters:
- N, 3, Johnson code width (legal range N >= 2); 2N legal states.
- IDX_W, $clog2(2*N), width of bin_out (3 for N=3).
- CNT_W, 8, width of wrap_count.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- sample_en  in  1  one-cycle strobe; code_in is valid and is sampled this cycle.
- code_in  in  N  Johnson code from the counter.
- clr_err  in  1  synchronous clear of err_sticky.
- bin_out  out  IDX_W  decoded index of the last legal sample.
- code_valid  out  1  high while in LOCKED state.
- dir_up  out  1  1 = last step was +1, 0 = last step was -1.
- step_err  out  1  one-cycle pulse on an illegal code or a skipped step.
- err_sticky  out  1  latched error flag.
- wrap_pulse  out  1  one-cycle pulse on any wrap.
- wrap_count  out  CNT_W  up-wraps minus down-wraps, modulo 2^CNT_W.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=EMPTY.
  - bin_out=0, code_valid=0, dir_up=1, step_err=0, err_sticky=0, wrap_pulse=0, wrap_count=0.
- Decode rule (combinational on code_in):
  - code==0 -> idx 0.
  - code[0]==1 with k ones contiguous from the LSB -> idx k (1..N).
  - code[0]==0 with k ones contiguous from the MSB -> idx 2N-k (N+1..2N-1).
  - Anything else is illegal.
  - N=3 map: 000=0, 001=1, 011=2, 111=3, 110=4, 100=5; 010 and 101 are illegal.
- Latency: all outputs update on the clock edge at which sample_en=1 is seen (registered, one cycle). Without sample_en, everything holds except the pulses, which drop to 0.
- FSM states: EMPTY, LOCKED, FAULT.
- EMPTY:
  - Legal sample -> LOCKED; bin_out=idx; code_valid=1; no dir or wrap update.
  - Illegal sample -> stay EMPTY; step_err=1; err_sticky=1.
- LOCKED, with d = (idx - bin_out) mod 2N:
  - d=0 -> hold all outputs.
  - d=1 -> bin_out=idx, dir_up=1. If bin_out was 2N-1 (wrap to 0): wrap_count+1, wrap_pulse=1.
  - d=2N-1 -> bin_out=idx, dir_up=0. If bin_out was 0 (wrap to 2N-1): wrap_count-1, wrap_pulse=1.
  - Illegal code or any other d -> FAULT; code_valid=0; step_err=1; err_sticky=1; bin_out holds.
- FAULT:
  - Legal sample -> LOCKED (resync); bin_out=idx; code_valid=1; dir and wrap_count unchanged; no wrap_pulse.
  - Illegal sample -> stay FAULT; step_err=1.
- wrap_count wraps silently: 2^CNT_W-1 +1 -> 0, and 0 -1 -> 2^CNT_W-1.
- clr_err=1 clears err_sticky on the next edge. If an error is detected in the same cycle, the set wins (err_sticky=1).
- clr_err does not change the FSM state; leaving FAULT requires a legal sample.
- Reset asserted mid-operation returns immediately to the reset values above; the first sample after reset goes through EMPTY.

Decomposition:
- Shared package `johnson_pkg`:
  - state enum (EMPTY=2'd0, LOCKED=2'd1, FAULT=2'd2);
  - a function computing IDX_W from N;
  - illegal-code constants for N=3 (3'b010, 3'b101).
- One natural sub-module: `johnson_to_bin`.
  - Purely combinational.
  - Inputs: code (N bits).
  - Outputs: idx (IDX_W bits), legal (1 bit).
  - Reused by later Johnson-code consumers.
- The top module holds the FSM, step check, wrap logic and error flags.

Test Plan:
- Reset then up-sequence: reset=0 for 2 cycles, then strobe 000, 001, 011, 111, 110, 100, 000 -> bin_out 0,1,2,3,4,5,0; dir_up=1; code_valid=1 from the first sample; wrap_count=1 with one wrap_pulse on the final sample.
- Down-sequence across the wrap: lock at 000, then strobe 100, 110 -> bin_out 5, 4; dir_up=0; wrap_count=8'hFF; wrap_pulse on the first step only.
- Illegal code: lock at 011, strobe 010 -> step_err pulse; err_sticky=1; code_valid=0; bin_out stays 2. Strobe 111 -> LOCKED; bin_out=3; code_valid=1; err_sticky still 1.
- Skip: lock at 001, strobe 111 (d=2) -> FAULT; step_err=1. Assert clr_err with no new error -> err_sticky=0; state still FAULT until the next legal sample.
- Simultaneous events: clr_err=1 in the same cycle as an illegal 101 sample -> err_sticky=1.
- Reset mid-run: with wrap_count=3 and LOCKED at idx 4, pulse reset=0 asynchronously between edges -> all outputs return to reset values immediately; next sample 110 -> LOCKED at bin_out=4 with wrap_count=0.
